// File: rtl/axi_port_router.sv
// Address-decoding demultiplexer from one AXI4 slave port to NoMstPorts master ports.
// Unmapped addresses are answered with DECERR by a built-in error slave.
module axi_port_router #(
    parameter int unsigned NoMstPorts = 2,
    parameter int unsigned NoRules    = 2,
    parameter int unsigned AddrWidth  = 32,
    parameter int unsigned DataWidth  = 32,
    parameter int unsigned IdWidth    = 4,
    parameter int unsigned MaxTrans   = 4,
    localparam int unsigned IdxW      = (NoMstPorts > 1) ? $clog2(NoMstPorts) : 1,
    localparam int unsigned RuleW     = IdxW + 2 * AddrWidth,
    localparam int unsigned StrbW     = DataWidth / 8
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic [NoRules*RuleW-1:0]         addr_map_i,
    input  logic                             en_default_i,
    input  logic [IdxW-1:0]                  default_idx_i,
    // slave side
    input  logic                             slv_aw_valid_i,
    output logic                             slv_aw_ready_o,
    input  logic [IdWidth-1:0]               slv_aw_id_i,
    input  logic [AddrWidth-1:0]             slv_aw_addr_i,
    input  logic [7:0]                       slv_aw_len_i,
    input  logic                             slv_w_valid_i,
    output logic                             slv_w_ready_o,
    input  logic [DataWidth-1:0]             slv_w_data_i,
    input  logic [StrbW-1:0]                 slv_w_strb_i,
    input  logic                             slv_w_last_i,
    output logic                             slv_b_valid_o,
    input  logic                             slv_b_ready_i,
    output logic [IdWidth-1:0]               slv_b_id_o,
    output logic [1:0]                       slv_b_resp_o,
    input  logic                             slv_ar_valid_i,
    output logic                             slv_ar_ready_o,
    input  logic [IdWidth-1:0]               slv_ar_id_i,
    input  logic [AddrWidth-1:0]             slv_ar_addr_i,
    input  logic [7:0]                       slv_ar_len_i,
    output logic                             slv_r_valid_o,
    input  logic                             slv_r_ready_i,
    output logic [IdWidth-1:0]               slv_r_id_o,
    output logic [DataWidth-1:0]             slv_r_data_o,
    output logic [1:0]                       slv_r_resp_o,
    output logic                             slv_r_last_o,
    // master side
    output logic [NoMstPorts-1:0]            mst_aw_valid_o,
    input  logic [NoMstPorts-1:0]            mst_aw_ready_i,
    output logic [IdWidth-1:0]               mst_aw_id_o,
    output logic [AddrWidth-1:0]             mst_aw_addr_o,
    output logic [7:0]                       mst_aw_len_o,
    output logic [NoMstPorts-1:0]            mst_w_valid_o,
    input  logic [NoMstPorts-1:0]            mst_w_ready_i,
    output logic [DataWidth-1:0]             mst_w_data_o,
    output logic [StrbW-1:0]                 mst_w_strb_o,
    output logic                             mst_w_last_o,
    input  logic [NoMstPorts-1:0]            mst_b_valid_i,
    output logic [NoMstPorts-1:0]            mst_b_ready_o,
    input  logic [NoMstPorts*IdWidth-1:0]    mst_b_id_i,
    input  logic [NoMstPorts*2-1:0]          mst_b_resp_i,
    output logic [NoMstPorts-1:0]            mst_ar_valid_o,
    input  logic [NoMstPorts-1:0]            mst_ar_ready_i,
    output logic [IdWidth-1:0]               mst_ar_id_o,
    output logic [AddrWidth-1:0]             mst_ar_addr_o,
    output logic [7:0]                       mst_ar_len_o,
    input  logic [NoMstPorts-1:0]            mst_r_valid_i,
    output logic [NoMstPorts-1:0]            mst_r_ready_o,
    input  logic [NoMstPorts*IdWidth-1:0]    mst_r_id_i,
    input  logic [NoMstPorts*DataWidth-1:0]  mst_r_data_i,
    input  logic [NoMstPorts*2-1:0]          mst_r_resp_i,
    input  logic [NoMstPorts-1:0]            mst_r_last_i
);
    localparam int unsigned CntW = $clog2(MaxTrans + 1);

    typedef struct packed {
        logic            err;
        logic [IdxW-1:0] idx;
    } tgt_t;

    typedef enum logic [1:0] {EW_IDLE, EW_DATA, EW_RESP} err_wr_e;
    typedef enum logic       {ER_IDLE, ER_RESP}          err_rd_e;

    // Later rules override earlier ones; rules naming a nonexistent port never match.
    function automatic tgt_t decode(input logic [AddrWidth-1:0]     addr,
                                    input logic [NoRules*RuleW-1:0] map,
                                    input logic                     en_def,
                                    input logic [IdxW-1:0]          def_idx);
        tgt_t                 t;
        logic [RuleW-1:0]     rule;
        logic [IdxW-1:0]      idx;
        logic [AddrWidth-1:0] start_addr, end_addr;
        t.err = !en_def;
        t.idx = en_def ? def_idx : '0;
        for (int r = 0; r < int'(NoRules); r++) begin
            rule       = map[r*RuleW +: RuleW];
            end_addr   = rule[AddrWidth-1:0];
            start_addr = rule[2*AddrWidth-1:AddrWidth];
            idx        = rule[RuleW-1 -: IdxW];
            if (addr >= start_addr && addr < end_addr && 32'(idx) < NoMstPorts) begin
                t.err = 1'b0;
                t.idx = idx;
            end
        end
        return t;
    endfunction

    tgt_t            aw_tgt, ar_tgt, wr_lock, rd_lock;
    logic [CntW-1:0] wr_cnt, w_cnt, rd_cnt;
    logic            aw_stall, ar_stall, aw_hs, ar_hs, w_last_hs, b_hs, r_hs, r_last_hs;
    err_wr_e         ew_q, ew_d;
    err_rd_e         er_q, er_d;
    logic [IdWidth-1:0] ew_id_q, er_id_q;
    logic [7:0]      er_len_q, er_beat_q;

    assign mst_aw_id_o   = slv_aw_id_i;
    assign mst_aw_addr_o = slv_aw_addr_i;
    assign mst_aw_len_o  = slv_aw_len_i;
    assign mst_w_data_o  = slv_w_data_i;
    assign mst_w_strb_o  = slv_w_strb_i;
    assign mst_w_last_o  = slv_w_last_i;
    assign mst_ar_id_o   = slv_ar_id_i;
    assign mst_ar_addr_o = slv_ar_addr_i;
    assign mst_ar_len_o  = slv_ar_len_i;

    // Write side: AW, W and B routing.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        mst_aw_valid_o = '0;
        slv_aw_ready_o = 1'b0;
        mst_w_valid_o  = '0;
        slv_w_ready_o  = 1'b0;
        mst_b_ready_o  = '0;
        slv_b_valid_o  = 1'b0;
        slv_b_id_o     = '0;
        slv_b_resp_o   = 2'b00;
        aw_tgt   = decode(slv_aw_addr_i, addr_map_i, en_default_i, default_idx_i);
        aw_stall = (wr_cnt == CntW'(MaxTrans)) || (wr_cnt != '0 && aw_tgt != wr_lock);
        if (rst_ni && !aw_stall) begin
            if (aw_tgt.err) begin
                slv_aw_ready_o = (ew_q == EW_IDLE);
            end else begin
                slv_aw_ready_o = mst_aw_ready_i[aw_tgt.idx];
                mst_aw_valid_o[aw_tgt.idx] = slv_aw_valid_i;
            end
        end
        if (rst_ni && w_cnt != '0) begin
            if (wr_lock.err) begin
                slv_w_ready_o = (ew_q == EW_DATA);
            end else begin
                slv_w_ready_o = mst_w_ready_i[wr_lock.idx];
                mst_w_valid_o[wr_lock.idx] = slv_w_valid_i;
            end
        end
        if (rst_ni && wr_cnt != '0) begin
            if (wr_lock.err) begin
                slv_b_valid_o = (ew_q == EW_RESP);
                slv_b_id_o    = ew_id_q;
                slv_b_resp_o  = 2'b11;
            end else begin
                slv_b_valid_o = mst_b_valid_i[wr_lock.idx];
                slv_b_id_o    = mst_b_id_i[wr_lock.idx*IdWidth +: IdWidth];
                slv_b_resp_o  = mst_b_resp_i[wr_lock.idx*2 +: 2];
                mst_b_ready_o[wr_lock.idx] = slv_b_ready_i;
            end
        end
        aw_hs     = slv_aw_valid_i && slv_aw_ready_o;
        w_last_hs = slv_w_valid_i && slv_w_ready_o && slv_w_last_i;
        b_hs      = slv_b_valid_o && slv_b_ready_i;
        ew_d = ew_q;
        case (ew_q)
            EW_IDLE: if (aw_hs && aw_tgt.err)     ew_d = EW_DATA;
            EW_DATA: if (w_last_hs && wr_lock.err) ew_d = EW_RESP;
            EW_RESP: if (b_hs)                     ew_d = EW_IDLE;
            default:                               ew_d = EW_IDLE;
        endcase
    end

    // Read side: AR and R routing.
    always_comb begin
        mst_ar_valid_o = '0;
        slv_ar_ready_o = 1'b0;
        mst_r_ready_o  = '0;
        slv_r_valid_o  = 1'b0;
        slv_r_id_o     = '0;
        slv_r_data_o   = '0;
        slv_r_resp_o   = 2'b00;
        slv_r_last_o   = 1'b0;
        ar_tgt   = decode(slv_ar_addr_i, addr_map_i, en_default_i, default_idx_i);
        ar_stall = (rd_cnt == CntW'(MaxTrans)) || (rd_cnt != '0 && ar_tgt != rd_lock);
        if (rst_ni && !ar_stall) begin
            if (ar_tgt.err) begin
                slv_ar_ready_o = (er_q == ER_IDLE);
            end else begin
                slv_ar_ready_o = mst_ar_ready_i[ar_tgt.idx];
                mst_ar_valid_o[ar_tgt.idx] = slv_ar_valid_i;
            end
        end
        if (rst_ni && rd_cnt != '0) begin
            if (rd_lock.err) begin
                slv_r_valid_o = (er_q == ER_RESP);
                slv_r_id_o    = er_id_q;
                slv_r_resp_o  = 2'b11;
                slv_r_last_o  = (er_beat_q == er_len_q);
            end else begin
                slv_r_valid_o = mst_r_valid_i[rd_lock.idx];
                slv_r_id_o    = mst_r_id_i[rd_lock.idx*IdWidth +: IdWidth];
                slv_r_data_o  = mst_r_data_i[rd_lock.idx*DataWidth +: DataWidth];
                slv_r_resp_o  = mst_r_resp_i[rd_lock.idx*2 +: 2];
                slv_r_last_o  = mst_r_last_i[rd_lock.idx];
                mst_r_ready_o[rd_lock.idx] = slv_r_ready_i;
            end
        end
        ar_hs     = slv_ar_valid_i && slv_ar_ready_o;
        r_hs      = slv_r_valid_o && slv_r_ready_i;
        r_last_hs = r_hs && slv_r_last_o;
        er_d = er_q;
        case (er_q)
            ER_IDLE: if (ar_hs && ar_tgt.err)                 er_d = ER_RESP;
            ER_RESP: if (r_last_hs && rd_lock.err)            er_d = ER_IDLE;
            default:                                          er_d = ER_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (!rst_ni) begin
            wr_cnt    <= '0;
            w_cnt     <= '0;
            rd_cnt    <= '0;
            wr_lock   <= '0;
            rd_lock   <= '0;
            ew_q      <= EW_IDLE;
            er_q      <= ER_IDLE;
            ew_id_q   <= '0;
            er_id_q   <= '0;
            er_len_q  <= '0;
            er_beat_q <= '0;
        end else begin
            // A simultaneous accept and retire leaves the count, and thus the lock, unchanged.
            wr_cnt <= wr_cnt + CntW'(aw_hs) - CntW'(b_hs);
            w_cnt  <= w_cnt + CntW'(aw_hs) - CntW'(w_last_hs);
            rd_cnt <= rd_cnt + CntW'(ar_hs) - CntW'(r_last_hs);
            if (aw_hs) wr_lock <= aw_tgt;
            if (ar_hs) rd_lock <= ar_tgt;
            ew_q <= ew_d;
            er_q <= er_d;
            if (aw_hs && aw_tgt.err) ew_id_q <= slv_aw_id_i;
            if (ar_hs && ar_tgt.err) begin
                er_id_q   <= slv_ar_id_i;
                er_len_q  <= slv_ar_len_i;
                er_beat_q <= '0;
            end else if (er_q == ER_RESP && r_hs) begin
                er_beat_q <= er_beat_q + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_axi_port_router.sv
// Directed self-checking bench for axi_port_router: routing, DECERR slave, locks,
// outstanding limit and mid-burst reset.
module tb_axi_port_router;
    localparam int NP = 2, NR = 2, AW = 32, DW = 32, IW = 4, IDXW = 1;
    localparam int RW = IDXW + 2 * AW;

    logic clk_i = 1'b0;
    logic rst_ni;
    logic [NR*RW-1:0] addr_map_i;
    logic en_default_i;
    logic [IDXW-1:0] default_idx_i;
    logic slv_aw_valid_i, slv_aw_ready_o;
    logic [IW-1:0] slv_aw_id_i;
    logic [AW-1:0] slv_aw_addr_i;
    logic [7:0] slv_aw_len_i;
    logic slv_w_valid_i, slv_w_ready_o, slv_w_last_i;
    logic [DW-1:0] slv_w_data_i;
    logic [DW/8-1:0] slv_w_strb_i;
    logic slv_b_valid_o, slv_b_ready_i;
    logic [IW-1:0] slv_b_id_o;
    logic [1:0] slv_b_resp_o;
    logic slv_ar_valid_i, slv_ar_ready_o;
    logic [IW-1:0] slv_ar_id_i;
    logic [AW-1:0] slv_ar_addr_i;
    logic [7:0] slv_ar_len_i;
    logic slv_r_valid_o, slv_r_ready_i, slv_r_last_o;
    logic [IW-1:0] slv_r_id_o;
    logic [DW-1:0] slv_r_data_o;
    logic [1:0] slv_r_resp_o;
    logic [NP-1:0] mst_aw_valid_o, mst_aw_ready_i;
    logic [IW-1:0] mst_aw_id_o;
    logic [AW-1:0] mst_aw_addr_o;
    logic [7:0] mst_aw_len_o;
    logic [NP-1:0] mst_w_valid_o, mst_w_ready_i;
    logic [DW-1:0] mst_w_data_o;
    logic [DW/8-1:0] mst_w_strb_o;
    logic mst_w_last_o;
    logic [NP-1:0] mst_b_valid_i, mst_b_ready_o;
    logic [NP*IW-1:0] mst_b_id_i;
    logic [NP*2-1:0] mst_b_resp_i;
    logic [NP-1:0] mst_ar_valid_o, mst_ar_ready_i;
    logic [IW-1:0] mst_ar_id_o;
    logic [AW-1:0] mst_ar_addr_o;
    logic [7:0] mst_ar_len_o;
    logic [NP-1:0] mst_r_valid_i, mst_r_ready_o, mst_r_last_i;
    logic [NP*IW-1:0] mst_r_id_i;
    logic [NP*DW-1:0] mst_r_data_i;
    logic [NP*2-1:0] mst_r_resp_i;

    int n_checks = 0;
    int n_fail   = 0;

    axi_port_router dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .addr_map_i(addr_map_i),
        .en_default_i(en_default_i), .default_idx_i(default_idx_i),
        .slv_aw_valid_i(slv_aw_valid_i), .slv_aw_ready_o(slv_aw_ready_o), .slv_aw_id_i(slv_aw_id_i),
        .slv_aw_addr_i(slv_aw_addr_i), .slv_aw_len_i(slv_aw_len_i),
        .slv_w_valid_i(slv_w_valid_i), .slv_w_ready_o(slv_w_ready_o), .slv_w_data_i(slv_w_data_i),
        .slv_w_strb_i(slv_w_strb_i), .slv_w_last_i(slv_w_last_i),
        .slv_b_valid_o(slv_b_valid_o), .slv_b_ready_i(slv_b_ready_i), .slv_b_id_o(slv_b_id_o),
        .slv_b_resp_o(slv_b_resp_o),
        .slv_ar_valid_i(slv_ar_valid_i), .slv_ar_ready_o(slv_ar_ready_o), .slv_ar_id_i(slv_ar_id_i),
        .slv_ar_addr_i(slv_ar_addr_i), .slv_ar_len_i(slv_ar_len_i),
        .slv_r_valid_o(slv_r_valid_o), .slv_r_ready_i(slv_r_ready_i), .slv_r_id_o(slv_r_id_o),
        .slv_r_data_o(slv_r_data_o), .slv_r_resp_o(slv_r_resp_o), .slv_r_last_o(slv_r_last_o),
        .mst_aw_valid_o(mst_aw_valid_o), .mst_aw_ready_i(mst_aw_ready_i), .mst_aw_id_o(mst_aw_id_o),
        .mst_aw_addr_o(mst_aw_addr_o), .mst_aw_len_o(mst_aw_len_o),
        .mst_w_valid_o(mst_w_valid_o), .mst_w_ready_i(mst_w_ready_i), .mst_w_data_o(mst_w_data_o),
        .mst_w_strb_o(mst_w_strb_o), .mst_w_last_o(mst_w_last_o),
        .mst_b_valid_i(mst_b_valid_i), .mst_b_ready_o(mst_b_ready_o), .mst_b_id_i(mst_b_id_i),
        .mst_b_resp_i(mst_b_resp_i),
        .mst_ar_valid_o(mst_ar_valid_o), .mst_ar_ready_i(mst_ar_ready_i), .mst_ar_id_o(mst_ar_id_o),
        .mst_ar_addr_o(mst_ar_addr_o), .mst_ar_len_o(mst_ar_len_o),
        .mst_r_valid_i(mst_r_valid_i), .mst_r_ready_o(mst_r_ready_o), .mst_r_id_i(mst_r_id_i),
        .mst_r_data_i(mst_r_data_i), .mst_r_resp_i(mst_r_resp_i), .mst_r_last_i(mst_r_last_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        addr_map_i = {1'b1, 32'h1000, 32'h2000, 1'b0, 32'h0000, 32'h1000};
        en_default_i = 1'b0; default_idx_i = '0;
        slv_aw_valid_i = 0; slv_aw_id_i = '0; slv_aw_addr_i = '0; slv_aw_len_i = '0;
        slv_w_valid_i = 0; slv_w_data_i = '0; slv_w_strb_i = 4'hF; slv_w_last_i = 0;
        slv_b_ready_i = 1; slv_ar_valid_i = 0; slv_ar_id_i = '0; slv_ar_addr_i = '0;
        slv_ar_len_i = '0; slv_r_ready_i = 0;
        mst_aw_ready_i = 2'b11; mst_w_ready_i = 2'b11; mst_ar_ready_i = 2'b11;
        mst_b_valid_i = '0; mst_b_id_i = '0; mst_b_resp_i = '0;
        mst_r_valid_i = '0; mst_r_id_i = '0; mst_r_data_i = '0; mst_r_resp_i = '0; mst_r_last_i = '0;

        // Reset: requests are ignored, nothing valid.
        rst_ni = 0; slv_aw_valid_i = 1; slv_aw_addr_i = 32'h1800; slv_ar_valid_i = 1;
        repeat (2) tick();
        check("rst_aw_valid", mst_aw_valid_o, 2'b00);
        check("rst_aw_ready", slv_aw_ready_o, 0);
        check("rst_ar_valid", mst_ar_valid_o, 2'b00);
        check("rst_b_valid", slv_b_valid_o, 0);
        check("rst_r_valid", slv_r_valid_o, 0);
        slv_aw_valid_i = 0; slv_ar_valid_i = 0; rst_ni = 1;
        tick();

        // W with no outstanding AW is blocked.
        slv_w_valid_i = 1; slv_w_last_i = 1; #1;
        check("w_idle_ready", slv_w_ready_o, 0);
        check("w_idle_valid", mst_w_valid_o, 2'b00);
        slv_w_valid_i = 0;

        // Write to port 1.
        slv_aw_valid_i = 1; slv_aw_addr_i = 32'h1800; slv_aw_id_i = 4'd3; #1;
        check("aw1_valid", mst_aw_valid_o, 2'b10);
        check("aw1_ready", slv_aw_ready_o, 1);
        check("aw1_id", mst_aw_id_o, 4'd3);
        tick(); slv_aw_valid_i = 0;
        slv_w_valid_i = 1; slv_w_data_i = 32'hCAFE0001; slv_w_last_i = 1; #1;
        check("w1_valid", mst_w_valid_o, 2'b10);
        check("w1_ready", slv_w_ready_o, 1);
        check("w1_data", mst_w_data_o, 32'hCAFE0001);
        tick(); slv_w_valid_i = 0;
        mst_b_valid_i = 2'b11; mst_b_id_i = {4'd3, 4'd5}; mst_b_resp_i = {2'b00, 2'b10}; #1;
        check("b1_valid", slv_b_valid_o, 1);
        check("b1_id", slv_b_id_o, 4'd3);
        check("b1_resp", slv_b_resp_o, 2'b00);
        check("b1_mst_ready", mst_b_ready_o, 2'b10);
        tick(); mst_b_valid_i = 0; #1;
        check("b1_done", slv_b_valid_o, 0);

        // Unmapped write goes to the error slave.
        slv_aw_valid_i = 1; slv_aw_addr_i = 32'h3000; slv_aw_id_i = 4'd9; #1;
        check("ew_aw_valid", mst_aw_valid_o, 2'b00);
        check("ew_aw_ready", slv_aw_ready_o, 1);
        tick(); slv_aw_valid_i = 0;
        slv_w_valid_i = 1; slv_w_last_i = 0; #1;
        check("ew_w0_ready", slv_w_ready_o, 1);
        check("ew_w0_mst", mst_w_valid_o, 2'b00);
        check("ew_b_early", slv_b_valid_o, 0);
        tick(); slv_w_last_i = 1; #1;
        check("ew_w1_ready", slv_w_ready_o, 1);
        tick(); slv_w_valid_i = 0; #1;
        check("ew_b_valid", slv_b_valid_o, 1);
        check("ew_b_id", slv_b_id_o, 4'd9);
        check("ew_b_resp", slv_b_resp_o, 2'b11);
        tick();
        check("ew_b_done", slv_b_valid_o, 0);

        // Unmapped read: 4 DECERR beats, held while not ready.
        slv_ar_valid_i = 1; slv_ar_addr_i = 32'h3000; slv_ar_id_i = 4'd6; slv_ar_len_i = 8'd3; #1;
        check("er_ar_valid", mst_ar_valid_o, 2'b00);
        check("er_ar_ready", slv_ar_ready_o, 1);
        tick(); slv_ar_valid_i = 0; #1;
        check("er_hold_valid", slv_r_valid_o, 1);
        tick();
        check("er_hold_last", slv_r_last_o, 0);
        check("er_mst_ready", mst_r_ready_o, 2'b00);
        slv_r_ready_i = 1; #1;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("er_r%0d_valid", i), slv_r_valid_o, 1);
            check($sformatf("er_r%0d_data", i), slv_r_data_o, 0);
            check($sformatf("er_r%0d_resp", i), slv_r_resp_o, 2'b11);
            check($sformatf("er_r%0d_id", i), slv_r_id_o, 4'd6);
            check($sformatf("er_r%0d_last", i), slv_r_last_o, (i == 3) ? 1 : 0);
            tick();
        end
        check("er_done", slv_r_valid_o, 0);

        // Same address with default port enabled goes to port 0.
        en_default_i = 1; default_idx_i = 1'b0;
        slv_ar_valid_i = 1; slv_ar_id_i = 4'd2; slv_ar_len_i = 8'd0; #1;
        check("df_ar_valid", mst_ar_valid_o, 2'b01);
        check("df_ar_ready", slv_ar_ready_o, 1);
        tick(); slv_ar_valid_i = 0;
        mst_r_valid_i = 2'b01; mst_r_id_i = {4'd0, 4'd2}; mst_r_data_i = {32'hDEAD, 32'h1234};
        mst_r_last_i = 2'b01; #1;
        check("df_r_valid", slv_r_valid_o, 1);
        check("df_r_data", slv_r_data_o, 32'h1234);
        check("df_r_mst_ready", mst_r_ready_o, 2'b01);
        tick(); mst_r_valid_i = 0; en_default_i = 0;

        // Write lock: AW to port 1 waits for port 0 to drain.
        slv_aw_valid_i = 1; slv_aw_addr_i = 32'h0100; slv_aw_id_i = 4'd1; #1;
        check("lk_aw0_valid", mst_aw_valid_o, 2'b01);
        tick(); slv_aw_addr_i = 32'h1800; slv_aw_id_i = 4'd2; #1;
        check("lk_stall_ready", slv_aw_ready_o, 0);
        check("lk_stall_valid", mst_aw_valid_o, 2'b00);
        slv_w_valid_i = 1; slv_w_last_i = 1; #1;
        check("lk_w0_valid", mst_w_valid_o, 2'b01);
        tick(); slv_w_valid_i = 0;
        mst_b_valid_i = 2'b01; mst_b_id_i = {4'd0, 4'd1}; mst_b_resp_i = '0; #1;
        check("lk_b0_valid", slv_b_valid_o, 1);
        check("lk_stall_in_b", slv_aw_ready_o, 0);
        tick(); mst_b_valid_i = 0; #1;
        check("lk_aw1_valid", mst_aw_valid_o, 2'b10);
        check("lk_aw1_ready", slv_aw_ready_o, 1);
        tick(); slv_aw_valid_i = 0;
        slv_w_valid_i = 1;
        tick(); slv_w_valid_i = 0;
        mst_b_valid_i = 2'b10; mst_b_id_i = {4'd2, 4'd0};
        tick(); mst_b_valid_i = 0;

        // Outstanding limit of 4 and simultaneous accept/retire.
        slv_w_valid_i = 1; slv_w_last_i = 1;
        slv_aw_valid_i = 1; slv_aw_addr_i = 32'h0010; slv_aw_id_i = 4'd4;
        for (int i = 0; i < 4; i++) begin
            #1; check($sformatf("mt_acc%0d", i), slv_aw_ready_o, 1);
            tick();
        end
        #1; check("mt_full", slv_aw_ready_o, 0);
        mst_b_valid_i = 2'b01; mst_b_id_i = {4'd0, 4'd4}; #1;
        check("mt_full_b", slv_aw_ready_o, 0);
        tick(); mst_b_valid_i = 0; #1;
        check("mt_after_b", slv_aw_ready_o, 1);
        tick(); #1;
        check("mt_full2", slv_aw_ready_o, 0);
        mst_b_valid_i = 2'b01;
        tick(); #1;
        check("mt_simul_ready", slv_aw_ready_o, 1);
        tick(); mst_b_valid_i = 0; #1;
        check("mt_simul_keep", slv_aw_ready_o, 1);
        tick(); #1;
        check("mt_full3", slv_aw_ready_o, 0);
        slv_aw_valid_i = 0; mst_b_valid_i = 2'b01;
        repeat (4) tick();
        mst_b_valid_i = 0; slv_w_valid_i = 0;
        slv_aw_valid_i = 1; slv_aw_addr_i = 32'h1800; #1;
        check("mt_drain_valid", mst_aw_valid_o, 2'b10);
        check("mt_drain_ready", slv_aw_ready_o, 1);
        slv_aw_valid_i = 0; #1;

        // Reset in the middle of an error read burst.
        slv_ar_valid_i = 1; slv_ar_addr_i = 32'h3000; slv_ar_id_i = 4'd7; slv_ar_len_i = 8'd7;
        tick(); slv_ar_valid_i = 0;
        repeat (2) tick();
        check("rs_mid_valid", slv_r_valid_o, 1);
        slv_ar_valid_i = 1; slv_ar_addr_i = 32'h0200; slv_ar_len_i = 8'd0; rst_ni = 0; #1;
        check("rs_r_valid", slv_r_valid_o, 0);
        check("rs_ar_ready", slv_ar_ready_o, 0);
        check("rs_ar_mvalid", mst_ar_valid_o, 2'b00);
        tick(); rst_ni = 1; #1;
        check("rs_r_after", slv_r_valid_o, 0);
        check("rs_ar_new_valid", mst_ar_valid_o, 2'b01);
        check("rs_ar_new_ready", slv_ar_ready_o, 1);
        tick(); slv_ar_valid_i = 0;
        mst_r_valid_i = 2'b01; mst_r_id_i = {4'd0, 4'd7}; mst_r_data_i = {32'h0, 32'h00BEEF00};
        mst_r_last_i = 2'b01; #1;
        check("rs_r_fwd_valid", slv_r_valid_o, 1);
        check("rs_r_fwd_data", slv_r_data_o, 32'h00BEEF00);
        tick(); mst_r_valid_i = 0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
